// File: rtl/dcache_ctrl.sv
// Sequencing controller for an 8-set direct-mapped write-through data cache.
// Define DCACHE_PERF_CNT_EN to add hit/miss performance counters (hit_cnt, miss_cnt, perf_clr).
module dcache_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SET_BITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic                  cache_we,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  output logic                  cache_inv,
  output logic [SET_BITS-1:0]   cache_inv_set,
  input  logic                  cache_hit,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
`ifdef DCACHE_PERF_CNT_EN
  input  logic                  perf_clr,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt,
`endif
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  // state     | meaning
  // S_FLUSH   | invalidate sweep, one set per cycle
  // S_IDLE    | accept CPU access or flush request; read hits served here
  // S_RD_MISS | waiting for memory read data
  // S_FILL    | write fetched line into array and return it to the CPU
  // S_WR_THRU | waiting for memory write completion
  localparam logic [2:0] S_FLUSH   = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_RD_MISS = 3'd2;
  localparam logic [2:0] S_FILL    = 3'd3;
  localparam logic [2:0] S_WR_THRU = 3'd4;

  localparam logic [SET_BITS-1:0] LAST_SET = {SET_BITS{1'b1}};

  logic [2:0]            state;
  logic [SET_BITS-1:0]   set_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] addr_al;
  logic                  idle_acc;
  logic                  ld_hit;
  logic                  ld_miss;
  logic                  st_go;

  assign addr_al  = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
  // flush_req outranks any CPU access presented in the same IDLE cycle
  assign idle_acc = (state == S_IDLE) && !flush_req && cpu_req;
  assign ld_hit   = idle_acc && !cpu_we && cache_hit;
  assign ld_miss  = idle_acc && !cpu_we && !cache_hit;
  assign st_go    = idle_acc && cpu_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FLUSH;
      set_cnt   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_FLUSH: begin
          set_cnt <= set_cnt + 1'b1;
          if (set_cnt == LAST_SET) state <= S_IDLE;
        end
        S_IDLE: begin
          if (flush_req) begin
            state   <= S_FLUSH;
            set_cnt <= '0;
          end else if (st_go) begin
            addr_q    <= addr_al;
            wdata_q   <= cpu_wdata;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= addr_al;
            mem_wdata <= cpu_wdata;
            state     <= S_WR_THRU;
          end else if (ld_miss) begin
            addr_q   <= addr_al;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= addr_al;
            state    <= S_RD_MISS;
          end
        end
        S_RD_MISS: begin
          if (mem_ack) begin
            rdata_q <= mem_rdata;
            mem_req <= 1'b0;
            state   <= S_FILL;
          end
        end
        S_FILL: state <= S_IDLE;
        S_WR_THRU: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: begin
          state   <= S_FLUSH;
          set_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    cpu_ready     = 1'b0;
    cpu_rdata     = rdata_q;
    cache_we      = 1'b0;
    cache_wdata   = wdata_q;
    cache_addr    = addr_q;
    cache_inv     = 1'b0;
    cache_inv_set = set_cnt;
    flush_busy    = 1'b0;
    case (state)
      S_FLUSH: begin
        cache_inv  = 1'b1;
        flush_busy = 1'b1;
      end
      S_IDLE: begin
        cache_addr = cpu_addr;
        if (ld_hit) begin
          cpu_ready = 1'b1;
          cpu_rdata = cache_rdata;
        end
      end
      S_FILL: begin
        cache_we    = 1'b1;
        cache_wdata = rdata_q;
        cpu_ready   = 1'b1;
      end
      S_WR_THRU: begin
        // write-allocate: the array is updated in the same cycle memory acknowledges
        if (mem_ack) begin
          cache_we  = 1'b1;
          cpu_ready = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef DCACHE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (perf_clr) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (ld_hit)  hit_cnt  <= hit_cnt + 32'd1;
      if (ld_miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: transaction-level cache/memory model with randomized accesses.
// Builds with or without DCACHE_PERF_CNT_EN.
module tb_dcache_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        flush_req, flush_busy;
  logic [31:0] cache_addr, cache_wdata, cache_rdata;
  logic        cache_we, cache_inv, cache_hit;
  logic [2:0]  cache_inv_set;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_PERF_CNT_EN
  logic        perf_clr;
  logic [31:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  dcache_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SET_BITS(3)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .cache_addr(cache_addr), .cache_we(cache_we), .cache_wdata(cache_wdata),
    .cache_inv(cache_inv), .cache_inv_set(cache_inv_set),
    .cache_hit(cache_hit), .cache_rdata(cache_rdata),
`ifdef DCACHE_PERF_CNT_EN
    .perf_clr(perf_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Cache array stand-in, driven only by the DUT's write/invalidate outputs
  logic        env_clr;
  logic        arr_v [8];
  logic [26:0] arr_t [8];
  logic [31:0] arr_d [8];
  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 8; i++) arr_v[i] <= 1'b0;
    end else begin
      if (cache_inv) arr_v[cache_inv_set] <= 1'b0;
      if (cache_we) begin
        arr_v[cache_addr[4:2]] <= 1'b1;
        arr_t[cache_addr[4:2]] <= cache_addr[31:5];
        arr_d[cache_addr[4:2]] <= cache_wdata;
      end
    end
  end
  assign cache_hit   = arr_v[cache_addr[4:2]] && (arr_t[cache_addr[4:2]] == cache_addr[31:5]);
  assign cache_rdata = arr_d[cache_addr[4:2]];

  // Reference: backing memory plus which line each set should hold
  logic [31:0] bmem [128];
  bit          mv [8];
  int          mt [8];
  int          hits_exp, misses_exp;

  int n_pass = 0;
  int n_tot  = 0;
  int          obs_ready_k;
  logic [31:0] obs_rdata, obs_maddr, obs_mwdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", nm, act, exp, $time);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mv[i] = 1'b0;
  endtask

  // Current negedge is the first sweep cycle; checks 8 sweep cycles then one idle cycle.
  task automatic check_flush_seq();
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        @(negedge clk);
        mem_ack = 1'b0;
      end
      #1;
      chk("sweep_busy", {31'd0, flush_busy}, {31'd0, k < 8});
      chk("sweep_inv", {31'd0, cache_inv}, {31'd0, k < 8});
      if (k < 8) chk("sweep_set", {29'd0, cache_inv_set}, k);
      chk("sweep_ready", {31'd0, cpu_ready}, 32'd0);
      chk("sweep_mem_req", {31'd0, mem_req}, 32'd0);
    end
    model_clear();
  endtask

  task automatic run_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                            input int dly, input bit fpre, input bit fmid);
    int w, set, tg, a, ready_k, mlo, mhi, ff, end_k, cnt;
    bit hit, anyf, exp_f, exp_mr, exp_rdy, exp_cwe, seen_m;
    logic [31:0] ldata, aal;
    w   = int'(addr[8:2]);
    set = int'(addr[4:2]);
    tg  = int'(addr[8:5]);
    aal = {addr[31:2], 2'b00};
    if (fpre) model_clear();
    hit   = !we && mv[set] && (mt[set] == tg);
    ldata = bmem[w];
    a   = fpre ? 9 : 0;
    mlo = a + 1;
    mhi = a + 1 + dly;
    if (hit) ready_k = a;
    else if (we) ready_k = mhi;
    else ready_k = mhi + 1;
    anyf  = fpre || fmid;
    ff    = fpre ? 1 : ready_k + 2;
    end_k = fmid ? ff + 8 : ready_k + 1;
    cnt = 0;
    seen_m = 1'b0;
    obs_ready_k = -1;
    obs_rdata = '0; obs_maddr = '0; obs_mwdata = '0;
    for (int k = 0; k <= end_k; k++) begin
      @(negedge clk);
      cpu_req   = (k <= ready_k);
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wd;
      flush_req = fpre ? (k == 0) : (fmid && k >= a + 1 && k < ff);
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (mem_req) begin
        if (cnt == dly) begin
          mem_ack   = 1'b1;
          mem_rdata = bmem[mem_addr[8:2]];
          if (mem_we) bmem[mem_addr[8:2]] = mem_wdata;
        end
        cnt++;
      end else if (k == end_k) begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      #1;
      exp_f   = anyf && k >= ff && k < ff + 8;
      exp_rdy = (k == ready_k);
      exp_mr  = !hit && k >= mlo && k <= mhi;
      exp_cwe = exp_rdy && !hit;
      chk("cpu_ready", {31'd0, cpu_ready}, {31'd0, exp_rdy});
      chk("flush_busy", {31'd0, flush_busy}, {31'd0, exp_f});
      chk("cache_inv", {31'd0, cache_inv}, {31'd0, exp_f});
      if (exp_f) chk("cache_inv_set", {29'd0, cache_inv_set}, k - ff);
      chk("mem_req", {31'd0, mem_req}, {31'd0, exp_mr});
      if (exp_mr) begin
        chk("mem_we", {31'd0, mem_we}, {31'd0, we});
        chk("mem_addr", mem_addr, aal);
        if (we) chk("mem_wdata", mem_wdata, wd);
      end
      chk("cache_we", {31'd0, cache_we}, {31'd0, exp_cwe});
      if (exp_cwe) begin
        chk("cache_wdata", cache_wdata, we ? wd : ldata);
        chk("cache_addr_wr", cache_addr, aal);
      end
      if (exp_rdy && hit) chk("cache_addr_lookup", cache_addr, addr);
      if (exp_rdy && !we) chk("cpu_rdata", cpu_rdata, ldata);
      if (cpu_ready && obs_ready_k < 0) begin
        obs_ready_k = k;
        obs_rdata   = cpu_rdata;
      end
      if (mem_req && !seen_m) begin
        seen_m     = 1'b1;
        obs_maddr  = mem_addr;
        obs_mwdata = mem_wdata;
      end
    end
    if (!hit) begin
      mv[set] = 1'b1;
      mt[set] = tg;
    end
    if (!we) begin
      if (hit) hits_exp++;
      else misses_exp++;
    end
    if (fmid) model_clear();
  endtask

  initial begin
    rst = 1'b1; env_clr = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    flush_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
`ifdef DCACHE_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    for (int i = 0; i < 128; i++) bmem[i] = $urandom;
    bmem[32'h40 >> 2] = 32'hDEADBEEF;
    bmem[32'h44 >> 2] = 32'h12345678;
    model_clear();
    hits_exp = 0; misses_exp = 0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
      chk("rst_cache_we", {31'd0, cache_we}, 32'd0);
      chk("rst_inv", {31'd0, cache_inv}, 32'd1);
      chk("rst_busy", {31'd0, flush_busy}, 32'd1);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0; env_clr = 1'b0;
    check_flush_seq();

    run_access(1'b0, 32'h0000_0040, 32'h0, 3, 1'b0, 1'b0);
    chk("lit_miss_latency", obs_ready_k, 32'd5);
    chk("lit_miss_rdata", obs_rdata, 32'hDEADBEEF);
    chk("lit_miss_maddr", obs_maddr, 32'h0000_0040);
    run_access(1'b0, 32'h0000_0044, 32'h0, 2, 1'b0, 1'b0);
    run_access(1'b0, 32'h0000_0044, 32'h0, 2, 1'b0, 1'b0);
    chk("lit_hit_latency", obs_ready_k, 32'd0);
    chk("lit_hit_rdata", obs_rdata, 32'h12345678);
    run_access(1'b0, 32'h0000_0044, 32'h0, 2, 1'b0, 1'b0);
    run_access(1'b0, 32'h0000_0040, 32'h0, 2, 1'b0, 1'b0);
    run_access(1'b1, 32'h0000_0107, 32'hCAFEF00D, 3, 1'b0, 1'b0);
    chk("lit_st_latency", obs_ready_k, 32'd4);
    chk("lit_st_maddr", obs_maddr, 32'h0000_0104);
    chk("lit_st_mwdata", obs_mwdata, 32'hCAFEF00D);
    chk("lit_st_mem", bmem[32'h104 >> 2], 32'hCAFEF00D);

`ifdef DCACHE_PERF_CNT_EN
    @(negedge clk); cpu_req = 1'b0; #1;
    chk("hit_cnt", hit_cnt, hits_exp);
    chk("miss_cnt", miss_cnt, misses_exp);
    chk("lit_hit_cnt", hit_cnt, 32'd3);
    chk("lit_miss_cnt", miss_cnt, 32'd2);
    @(negedge clk); perf_clr = 1'b1;
    @(negedge clk); perf_clr = 1'b0; #1;
    chk("clr_hit_cnt", hit_cnt, 32'd0);
    chk("clr_miss_cnt", miss_cnt, 32'd0);
    hits_exp = 0; misses_exp = 0;
`endif

    // flush together with a load that would hit: sweep first, then a refetch
    run_access(1'b0, 32'h0000_0044, 32'h0, 1, 1'b1, 1'b0);
    chk("lit_flush_first_latency", obs_ready_k, 32'd12);
    chk("lit_flush_first_rdata", obs_rdata, 32'h12345678);
    run_access(1'b0, 32'h0000_0040, 32'h0, 2, 1'b0, 1'b1);
    chk("lit_flush_mid_latency", obs_ready_k, 32'd4);

    // async reset while a read miss is outstanding
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0060; flush_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk); #1;
    chk("rmid_mem_req_before", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rmid_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rmid_busy", {31'd0, flush_busy}, 32'd1);
    chk("rmid_inv", {31'd0, cache_inv}, 32'd1);
    chk("rmid_ready", {31'd0, cpu_ready}, 32'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    check_flush_seq();
    hits_exp = 0; misses_exp = 0;

    for (int i = 0; i < 200; i++) begin
      int r, w;
      logic [31:0] ad;
      r  = $urandom_range(0, 19);
      w  = $urandom_range(0, 31);
      ad = (32'(w) << 2) | 32'($urandom_range(0, 3));
      run_access($urandom_range(0, 9) < 3, ad, $urandom, $urandom_range(0, 3), r == 0, r == 1);
    end

`ifdef DCACHE_PERF_CNT_EN
    @(negedge clk); cpu_req = 1'b0; #1;
    chk("rand_hit_cnt", hit_cnt, hits_exp);
    chk("rand_miss_cnt", miss_cnt, misses_exp);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
